// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle RV32M multiply/divide unit for the execute stage.
// Iterative shift-add multiplier and restoring divider, one bit per cycle,
// with a valid/ready handshake on both the operand and the result side.
// Optional build macro: ALU_MULDIV_FAST_MUL_EN selects a single-cycle
// multiply path (divide stays iterative); results are identical either way.
module alu_muldiv #(
  parameter int DATAWIDTH = 32,
  parameter int CNT_WIDTH = $clog2(DATAWIDTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 Valid_i,
  output logic                 Ready_o,
  input  logic [DATAWIDTH-1:0] SrcA_i,
  input  logic [DATAWIDTH-1:0] SrcB_i,
  input  logic [2:0]           Op_i,
  input  logic                 Flush_i,
  input  logic                 Ready_i,
  output logic                 Valid_o,
  output logic [DATAWIDTH-1:0] Result_o,
  output logic                 Busy_o
);
  localparam int W = DATAWIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;

  state_t             state_r, state_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic [2:0]         op_r;
  logic               neg_r;
  logic [W-1:0]       a_mag_r, b_mag_r;
  logic [2*W-1:0]     acc_r;
  logic [W-1:0]       result_r;
  logic               valid_r;

  logic               a_signed_s, b_signed_s, sign_a_s, sign_b_s, neg_s;
  logic [W-1:0]       a_mag_s, b_mag_s;
  logic               div_zero_s, div_ovf_s, special_s;
  logic [W-1:0]       special_res_s;
  logic               accept_s, fast_mul_s;
  logic [W-1:0]       fast_res_s;

  logic [W:0]         mul_sum_s;
  logic [2*W-1:0]     mul_next_s;
  logic [W:0]         div_shift_s;
  logic               div_ge_s;
  logic [W-1:0]       div_diff_s;
  logic [2*W-1:0]     div_next_s, acc_next_s, prod_fix_s;
  logic [W-1:0]       quot_fix_s, rem_fix_s, calc_res_s;
  logic               last_s;

`ifdef ALU_MULDIV_FAST_MUL_EN
  logic [2*W-1:0]     a_ext_s, b_ext_s, fast_prod_s;
`endif

  // Decode the incoming op: signedness, magnitudes and divide special cases.
  always_comb begin
    a_signed_s = (Op_i == 3'b001) || (Op_i == 3'b010) || (Op_i == 3'b100) || (Op_i == 3'b110);
    b_signed_s = (Op_i == 3'b001) || (Op_i == 3'b100) || (Op_i == 3'b110);
    sign_a_s   = a_signed_s & SrcA_i[W-1];
    sign_b_s   = b_signed_s & SrcB_i[W-1];
    a_mag_s    = sign_a_s ? (-SrcA_i) : SrcA_i;
    b_mag_s    = sign_b_s ? (-SrcB_i) : SrcB_i;
    // Remainder takes the dividend's sign; everything else takes the XOR.
    neg_s      = (Op_i[2] && Op_i[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
    div_zero_s = Op_i[2] && (SrcB_i == {W{1'b0}});
    div_ovf_s  = Op_i[2] && !Op_i[0] && (SrcA_i == MOST_NEG) && (SrcB_i == {W{1'b1}});
    special_s  = div_zero_s || div_ovf_s;
    if (div_zero_s) begin
      special_res_s = Op_i[1] ? SrcA_i : {W{1'b1}};
    end else if (div_ovf_s) begin
      special_res_s = Op_i[1] ? {W{1'b0}} : MOST_NEG;
    end else begin
      special_res_s = {W{1'b0}};
    end
    accept_s = Valid_i && !Flush_i;
`ifdef ALU_MULDIV_FAST_MUL_EN
    // Sign-extended operands; the low 2W bits of the product are exact.
    a_ext_s     = {{W{sign_a_s}}, SrcA_i};
    b_ext_s     = {{W{sign_b_s}}, SrcB_i};
    fast_prod_s = a_ext_s * b_ext_s;
    fast_mul_s  = !Op_i[2];
    fast_res_s  = (Op_i[1:0] == 2'b00) ? fast_prod_s[W-1:0] : fast_prod_s[2*W-1:W];
`else
    fast_mul_s  = 1'b0;
    fast_res_s  = {W{1'b0}};
`endif
  end

  // One iteration of the shift-add multiplier / restoring divider plus the final sign fix.
  always_comb begin
    mul_sum_s   = acc_r[0] ? ({1'b0, acc_r[2*W-1:W]} + {1'b0, a_mag_r}) : {1'b0, acc_r[2*W-1:W]};
    mul_next_s  = {mul_sum_s, acc_r[W-1:1]};
    div_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
    div_ge_s    = (div_shift_s >= {1'b0, b_mag_r});
    div_diff_s  = div_shift_s[W-1:0] - b_mag_r;
    div_next_s  = {(div_ge_s ? div_diff_s : div_shift_s[W-1:0]), acc_r[W-2:0], div_ge_s};
    acc_next_s  = op_r[2] ? div_next_s : mul_next_s;
    prod_fix_s  = neg_r ? (-acc_next_s) : acc_next_s;
    quot_fix_s  = neg_r ? (-acc_next_s[W-1:0]) : acc_next_s[W-1:0];
    rem_fix_s   = neg_r ? (-acc_next_s[2*W-1:W]) : acc_next_s[2*W-1:W];
    case (op_r)
      3'b000:                 calc_res_s = prod_fix_s[W-1:0];
      3'b001, 3'b010, 3'b011: calc_res_s = prod_fix_s[2*W-1:W];
      3'b100, 3'b101:         calc_res_s = quot_fix_s;
      3'b110, 3'b111:         calc_res_s = rem_fix_s;
      default:                calc_res_s = {W{1'b0}};
    endcase
    last_s = (cnt_r == CNT_WIDTH'(1));
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush outranks completion and result handoff.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = (special_s || fast_mul_s) ? ST_DONE : ST_CALC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (Flush_i)     state_s = ST_IDLE;
        else if (last_s) state_s = ST_DONE;
        else             state_s = ST_CALC;
      end
      ST_DONE: begin
        if (Flush_i || Ready_i) state_s = ST_IDLE;
        else                    state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded directly from state.
  always_comb begin
    Ready_o = (state_r == ST_IDLE);
    Busy_o  = (state_r != ST_IDLE);
  end

  // Datapath registers: operand latch, iteration, registered result and valid.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r    <= {CNT_WIDTH{1'b0}};
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      a_mag_r  <= {W{1'b0}};
      b_mag_r  <= {W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      result_r <= {W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= Op_i;
            neg_r   <= neg_s;
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
            // Low half holds the multiplier or the dividend being shifted out.
            acc_r   <= {{W{1'b0}}, (Op_i[2] ? a_mag_s : b_mag_s)};
            cnt_r   <= CNT_WIDTH'(W);
            if (special_s) begin
              result_r <= special_res_s;
              valid_r  <= 1'b1;
            end else if (fast_mul_s) begin
              result_r <= fast_res_s;
              valid_r  <= 1'b1;
            end else begin
              valid_r  <= 1'b0;
            end
          end else begin
            valid_r <= 1'b0;
          end
        end
        ST_CALC: begin
          if (Flush_i) begin
            cnt_r   <= {CNT_WIDTH{1'b0}};
            valid_r <= 1'b0;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r - CNT_WIDTH'(1);
            if (last_s) begin
              result_r <= calc_res_s;
              valid_r  <= 1'b1;
            end else begin
              valid_r  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          valid_r <= !(Flush_i || Ready_i);
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign Valid_o  = valid_r;
  assign Result_o = result_r;

endmodule
